// File: rtl/writeback_unit_if.sv
// ============================================================================
// Module      : writeback_unit_if
// Description : MEM-stage handshake and register-file write port bundle for
//               the writeback unit, plus its forwarding mirror.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_unit_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 3
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_wb_en;
  logic [1:0]               in_wb_sel;
  logic [DATA_WIDTH-1:0]    in_alu_result;
  logic [DATA_WIDTH-1:0]    in_mem_data;
  logic [DATA_WIDTH-1:0]    in_imm;
  logic [DATA_WIDTH-1:0]    in_port_data;
  logic [ADDRESS_WIDTH-1:0] in_dest;
  logic                     in_swap;
  logic [DATA_WIDTH-1:0]    in_swap_data;
  logic [ADDRESS_WIDTH-1:0] in_swap_dest;
  logic                     write_enable;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic                     fwd_valid;
  logic [ADDRESS_WIDTH-1:0] fwd_address;
  logic [DATA_WIDTH-1:0]    fwd_data;
  logic                     busy;

  // MEM-stage side: presents instructions, observes writes
  modport master (
    output flush, in_valid, in_wb_en, in_wb_sel, in_alu_result, in_mem_data,
           in_imm, in_port_data, in_dest, in_swap, in_swap_data, in_swap_dest,
    input  in_ready, write_enable, write_data, write_address,
           fwd_valid, fwd_address, fwd_data, busy
  );

  // Writeback unit side
  modport slave (
    input  flush, in_valid, in_wb_en, in_wb_sel, in_alu_result, in_mem_data,
           in_imm, in_port_data, in_dest, in_swap, in_swap_data, in_swap_dest,
    output in_ready, write_enable, write_data, write_address,
           fwd_valid, fwd_address, fwd_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module      : writeback_unit
// Description : MEM/WB pipeline register and register-file write sequencer.
//               Selects the writeback source, issues SWAP instructions as two
//               consecutive writes (stalling MEM during the first), and
//               mirrors the write port onto the forwarding bus.
//               Optional macro WB_ZERO_REG_EN: R0 reads as zero, so any write
//               addressed to R0 is suppressed (sequencing unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  writeback_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } state_t;

  localparam logic [1:0] c_sel_alu  = 2'b00;
  localparam logic [1:0] c_sel_mem  = 2'b01;
  localparam logic [1:0] c_sel_imm  = 2'b10;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_wb_en;
  logic                     r_swap;
  logic [DATA_WIDTH-1:0]    r_result;
  logic [ADDRESS_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0]    r_swap_data;
  logic [ADDRESS_WIDTH-1:0] r_swap_dest;

  logic                     w_ready;
  logic                     w_accept;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic                     w_we;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic                     w_zero_hit;

  // Stall MEM only while the first half of a real swap is on the port;
  // decoded purely from registered state.
  assign w_ready  = !((r_state == WR1) && r_swap && r_wb_en);
  assign w_accept = bus.in_valid && w_ready && !bus.flush;

  // Writeback source mux, evaluated at acceptance
  always_comb begin
    w_sel_data = bus.in_port_data;
    case (bus.in_wb_sel)
      c_sel_alu: w_sel_data = bus.in_alu_result;
      c_sel_mem: w_sel_data = bus.in_mem_data;
      c_sel_imm: w_sel_data = bus.in_imm;
      default:   w_sel_data = bus.in_port_data;
    endcase
  end

  // Next-state decode; flush cancels any pending second write and drops
  // whatever is presented in the same cycle
  always_comb begin
    w_state_next = IDLE;
    if (bus.flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        WR1:     w_state_next = (r_swap && r_wb_en) ? WR2 : (w_accept ? WR1 : IDLE);
        default: w_state_next = w_accept ? WR1 : IDLE;
      endcase
    end
  end

  // State register and MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wb_en     <= 1'b0;
      r_swap      <= 1'b0;
      r_result    <= '0;
      r_dest      <= '0;
      r_swap_data <= '0;
      r_swap_dest <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_wb_en     <= bus.in_wb_en;
        r_swap      <= bus.in_swap && bus.in_wb_en;
        r_result    <= w_sel_data;
        r_dest      <= bus.in_dest;
        r_swap_data <= bus.in_swap_data;
        r_swap_dest <= bus.in_swap_dest;
      end
    end
  end

  // Write-port drive for the current state; IDLE drives all zeros
  always_comb begin
    w_we   = 1'b0;
    w_data = '0;
    w_addr = '0;
    case (r_state)
      WR1: begin
        w_we   = r_wb_en;
        w_data = r_result;
        w_addr = r_dest;
      end
      WR2: begin
        w_we   = 1'b1;
        w_data = r_swap_data;
        w_addr = r_swap_dest;
      end
      default: begin
        w_we   = 1'b0;
        w_data = '0;
        w_addr = '0;
      end
    endcase
  end

`ifdef WB_ZERO_REG_EN
  assign w_zero_hit = (w_addr == '0);
`else
  assign w_zero_hit = 1'b0;
`endif

  assign bus.in_ready      = w_ready;
  assign bus.write_enable  = w_we && !w_zero_hit;
  assign bus.write_data    = w_data;
  assign bus.write_address = w_addr;
  assign bus.fwd_valid     = w_we && !w_zero_hit;
  assign bus.fwd_address   = w_addr;
  assign bus.fwd_data      = w_data;
  assign bus.busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module      : tb_writeback_unit
// Description : Directed self-checking bench for writeback_unit with a small
//               register-file model fed from the write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [15:0] rf [8];

  writeback_unit_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3)) bus ();

  writeback_unit #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model capturing the write port
  always @(posedge clk) begin
    if (bus.write_enable === 1'b1) rf[bus.write_address] <= bus.write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full write-port check, including the forwarding mirror
  task automatic chk_port(input string tag, input logic we, input logic [2:0] addr,
                          input logic [15:0] data, input logic busy, input logic rdy);
    chk({tag, ".we"},    32'(bus.write_enable),  32'(we));
    chk({tag, ".addr"},  32'(bus.write_address), 32'(addr));
    chk({tag, ".data"},  32'(bus.write_data),    32'(data));
    chk({tag, ".fwdv"},  32'(bus.fwd_valid),     32'(we));
    chk({tag, ".fwda"},  32'(bus.fwd_address),   32'(addr));
    chk({tag, ".fwdd"},  32'(bus.fwd_data),      32'(data));
    chk({tag, ".busy"},  32'(bus.busy),          32'(busy));
    chk({tag, ".ready"}, 32'(bus.in_ready),      32'(rdy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] sel, input logic [15:0] val, input logic [2:0] dest,
                         input logic swap, input logic [15:0] sdata, input logic [2:0] sdest);
    bus.in_valid      = 1'b1;
    bus.in_wb_en      = 1'b1;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = (sel == 2'b00) ? val : 16'h0A0A;
    bus.in_mem_data   = (sel == 2'b01) ? val : 16'h0B0B;
    bus.in_imm        = (sel == 2'b10) ? val : 16'h0C0C;
    bus.in_port_data  = (sel == 2'b11) ? val : 16'h0D0D;
    bus.in_dest       = dest;
    bus.in_swap       = swap;
    bus.in_swap_data  = sdata;
    bus.in_swap_dest  = sdest;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    bus.flush = 1'b0;
    present(2'b00, 16'h1234, 3'd3, 1'b0, 16'h0, 3'd0);

    // Reset held two cycles with an instruction presented
    rst = 1'b1;
    step();
    chk_port("rst1", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    step();
    chk_port("rst2", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk_port("idle", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);

    // Memory source select
    present(2'b01, 16'hBEEF, 3'd5, 1'b0, 16'h0, 3'd0);
    step();
    chk_port("memsel", 1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    step();
    chk_port("memsel_done", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("rf_r5", 32'(rf[5]), 32'h0000BEEF);

    // Back-to-back ALU / immediate / port
    present(2'b00, 16'h0001, 3'd1, 1'b0, 16'h0, 3'd0);
    step();
    chk_port("b2b_alu", 1'b1, 3'd1, 16'h0001, 1'b1, 1'b1);
    present(2'b10, 16'h0002, 3'd2, 1'b0, 16'h0, 3'd0);
    step();
    chk_port("b2b_imm", 1'b1, 3'd2, 16'h0002, 1'b1, 1'b1);
    present(2'b11, 16'h0003, 3'd3, 1'b0, 16'h0, 3'd0);
    step();
    chk_port("b2b_port", 1'b1, 3'd3, 16'h0003, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    step();
    chk_port("b2b_done", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("rf_r3", 32'(rf[3]), 32'h00000003);

    // Swap with a following instruction held off during WR1
    present(2'b00, 16'h1111, 3'd4, 1'b1, 16'h2222, 3'd6);
    step();
    chk_port("swap_wr1", 1'b1, 3'd4, 16'h1111, 1'b1, 1'b0);
    present(2'b00, 16'h5555, 3'd7, 1'b0, 16'h0, 3'd0);
    step();
    chk_port("swap_wr2", 1'b1, 3'd6, 16'h2222, 1'b1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk_port("swap_next", 1'b1, 3'd7, 16'h5555, 1'b1, 1'b1);
    step();
    chk_port("swap_done", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("rf_r6", 32'(rf[6]), 32'h00002222);

    // Same-address swap: second write wins
    present(2'b00, 16'hAAAA, 3'd2, 1'b1, 16'hBBBB, 3'd2);
    step();
    bus.in_valid = 1'b0;
    chk_port("same_wr1", 1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b0);
    step();
    chk_port("same_wr2", 1'b1, 3'd2, 16'hBBBB, 1'b1, 1'b1);
    step();
    chk("rf_r2", 32'(rf[2]), 32'h0000BBBB);

    // Flush during swap WR1, with an instruction presented alongside
    present(2'b00, 16'h4444, 3'd4, 1'b1, 16'h6666, 3'd6);
    step();
    chk_port("flush_wr1", 1'b1, 3'd4, 16'h4444, 1'b1, 1'b0);
    present(2'b00, 16'h7777, 3'd1, 1'b0, 16'h0, 3'd0);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk_port("flush_after", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    step();
    chk_port("flush_idle", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("rf_r4", 32'(rf[4]), 32'h00004444);
    chk("rf_r6_kept", 32'(rf[6]), 32'h00002222);
    chk("rf_r1_kept", 32'(rf[1]), 32'h00000001);

    // Bubble: wb_en low, swap ignored
    present(2'b00, 16'h9999, 3'd3, 1'b1, 16'h8888, 3'd5);
    bus.in_wb_en = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk_port("bubble", 1'b0, 3'd3, 16'h9999, 1'b1, 1'b1);
    step();
    chk_port("bubble_done", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("rf_r5_kept", 32'(rf[5]), 32'h0000BEEF);

    // Write to R0
    present(2'b00, 16'hFFFF, 3'd0, 1'b0, 16'h0, 3'd0);
    step();
    bus.in_valid = 1'b0;
`ifdef WB_ZERO_REG_EN
    chk_port("r0_write", 1'b0, 3'd0, 16'hFFFF, 1'b1, 1'b1);
`else
    chk_port("r0_write", 1'b1, 3'd0, 16'hFFFF, 1'b1, 1'b1);
`endif
    step();

    // Reset in the middle of a swap drops WR2
    present(2'b00, 16'h3333, 3'd5, 1'b1, 16'h4321, 3'd7);
    step();
    bus.in_valid = 1'b0;
    chk_port("rstswap_wr1", 1'b1, 3'd5, 16'h3333, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_port("rstswap_after", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    step();
    chk_port("rstswap_idle", 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("rf_r7_kept", 32'(rf[7]), 32'h00005555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
